// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared op encodings, FSM state type and iteration count for the MUL/DIV unit
package mcu51_pkg;

    localparam logic OP_MUL   = 1'b0;
    localparam logic OP_DIV   = 1'b1;
    localparam int   ITER_CNT = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add MUL or restoring DIV iteration (DIV path only with MCU51_DIV_EN)
module muldiv_step
    import mcu51_pkg::*;
#(
    parameter int DATA_W = 8
) (
`ifdef MCU51_DIV_EN
    input  logic              op_i,
`endif
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] opr_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opr_i} : '0);

`ifdef MCU51_DIV_EN
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] dif;
    logic              ge;

    assign rem  = {hi_i, lo_i[DATA_W-1]};
    assign ge   = rem >= {1'b0, opr_i};
    assign dif  = rem[DATA_W-1:0] - opr_i;
    assign hi_o = (op_i == OP_DIV) ? (ge ? dif : rem[DATA_W-1:0]) : sum[DATA_W:1];
    assign lo_o = (op_i == OP_DIV) ? {lo_i[DATA_W-2:0], ge} : {sum[0], lo_i[DATA_W-1:1]};
`else
    assign hi_o = sum[DATA_W:1];
    assign lo_o = {sum[0], lo_i[DATA_W-1:1]};
`endif

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: sequential 8051-style MUL AB / DIV AB unit; divide support gated by MCU51_DIV_EN
module alu_muldiv_seq
    import mcu51_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res_a,
    output logic [DATA_W-1:0] res_b,
    output logic              ov,
    output logic              cy
);

    localparam int CNT_W = $clog2(ITER_CNT);
`ifdef MCU51_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, opr_q, opr_d;
    logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d;
    logic              ov_q, ov_d, cy_q, cy_d;
    logic [DATA_W-1:0] hi_n, lo_n;

    // hi/lo hold {partial product} for MUL and {remainder, dividend/quotient} for DIV
    muldiv_step #(.DATA_W(DATA_W)) u_step (
`ifdef MCU51_DIV_EN
        .op_i  (op_q),
`endif
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .opr_i (opr_q),
        .hi_o  (hi_n),
        .lo_o  (lo_n)
    );

    // Next state: iterate in RUN, accept requests in IDLE/DONE, results latched only on DONE entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opr_d   = opr_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ov_d    = ov_q;
        cy_d    = cy_q;
        if (state_q == RUN) begin
            if (abort) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    ra_d    = lo_n;
                    rb_d    = hi_n;
                    ov_d    = (op_q == OP_MUL) && (hi_n != '0);
                    cy_d    = 1'b0;
                end
            end
        end else if (start) begin
            op_d = op;
            if (op == OP_DIV && (!DIV_EN || b_in == '0)) begin
                state_d = DONE;
                ra_d    = a_in;
                rb_d    = DIV_EN ? '0 : b_in;
                ov_d    = 1'b1;
                cy_d    = 1'b0;
            end else begin
                state_d = RUN;
                cnt_d   = CNT_W'(ITER_CNT - 1);
                hi_d    = '0;
                lo_d    = (op == OP_MUL) ? b_in : a_in;
                opr_d   = (op == OP_MUL) ? a_in : b_in;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            opr_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opr_q   <= opr_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ov_q    <= ov_d;
            cy_q    <= cy_d;
        end
    end

    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign res_a = ra_q;
    assign res_b = rb_q;
    assign ov    = ov_q;
    assign cy    = cy_q;

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 DATA_W, default 8, operand/result width; only 8 is a supported value.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request pulse; sampled only when the block accepts requests.
REQ-005 op  in  1  0 = MUL AB, 1 = DIV AB.
REQ-006 a_in  in  DATA_W  accumulator operand, captured with start.
REQ-007 b_in  in  DATA_W  B-register operand, captured with start.
REQ-008 abort  in  1  synchronous cancel of an operation in progress.
REQ-009 busy  out  1  high while the state is RUN or DONE.
REQ-010 done  out  1  single-cycle completion pulse.
REQ-011 res_a  out  DATA_W  MUL: product low byte; DIV: quotient.
REQ-012 res_b  out  DATA_W  MUL: product high byte; DIV: remainder.
REQ-013 ov  out  1  MUL: product > 0xFF; DIV: divisor zero.
REQ-014 cy  out  1  always 0 on completion (8051 MUL/DIV rule).

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE.
- IDLE->RUN on start, except DIV with b_in=0.
- IDLE->DONE on start with DIV and b_in=0.
- RUN->DONE after 8 iterations.
- RUN->IDLE on abort.
- DONE->IDLE, or DONE->RUN/DONE when start is present.
REQ-016 start SHALL be accepted in IDLE and DONE only; start in RUN SHALL be ignored with no side effect.
REQ-017 MUL SHALL use shift-add, one multiplier bit per cycle, LSB first, 16-bit accumulation.
REQ-018 DIV SHALL use restoring division, one quotient bit per cycle, MSB first, 9-bit partial remainder.
REQ-019 An iteration counter SHALL count 7 down to 0; RUN SHALL exit on the cycle the counter reaches 0.
REQ-020 Latency, with start sampled on edge k:
- normal operation: done SHALL be high between edges k+9 and k+10;
- DIV by zero: done SHALL be high between edges k+1 and k+2.
REQ-021 res_a, res_b, ov and cy SHALL be registered, update only on entry to DONE, and hold until the next completion.
REQ-022 DIV by zero SHALL give ov=1, cy=0, res_a=a_in and res_b=0x00.
REQ-023 abort in RUN SHALL:
- return the FSM to IDLE on the next edge;
- produce no done pulse;
- leave all result outputs unchanged.
abort SHALL have no effect outside RUN.
REQ-024 When abort and start are both asserted in RUN, abort SHALL win and start SHALL be dropped.
REQ-025 Back-to-back: start in DONE SHALL capture the new operands on that edge, so done pulses are exactly 9 cycles apart.
REQ-026 All arithmetic SHALL be unsigned; a_in and b_in SHALL not be sampled after the start edge.

Reset
REQ-027 rst_n low SHALL immediately force:
- state=IDLE and counter=0;
- busy=0, done=0;
- res_a=0x00, res_b=0x00, ov=0, cy=0.
REQ-028 Reset during RUN SHALL discard the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.

Configuration
REQ-029 Macro MCU51_DIV_EN SHALL control divide support.
- Defined: DIV behaves per REQ-018/020/022.
- Undefined: the divider datapath is absent; op=1 goes IDLE->DONE in 1 cycle with ov=1, cy=0, res_a=a_in, res_b=b_in.
- MUL behaviour SHALL be identical in both builds.

Structure
REQ-030 The shared package mcu51_pkg SHALL hold:
- the op encoding constants OP_MUL and OP_DIV;
- the FSM state typedef;
- the constant ITER_CNT=8.
REQ-031 One sub-module, muldiv_step, SHALL implement one combinational MUL/DIV iteration; the top SHALL hold the FSM, counter and registers.

Verification
REQ-032 MUL a=0x50, b=0xA0 -> after 9 cycles: res_a=0x00, res_b=0x32, ov=1, cy=0, one done pulse.
REQ-033 MUL a=0x0C, b=0x0A -> res_a=0x78, res_b=0x00, ov=0; also 0xFF*0xFF -> res_a=0x01, res_b=0xFE, ov=1.
REQ-034 DIV a=0xFB, b=0x12 -> res_a=0x0D, res_b=0x11, ov=0; DIV a=0x25, b=0x00 -> done 1 cycle after start, ov=1, res_a=0x25, res_b=0x00.
REQ-035 Abort and reset: abort at iteration 4 of MUL 0x12*0x34 -> no done, outputs keep prior values, busy=0 next cycle; the same check SHALL be repeated with rst_n pulsed low mid-RUN, expecting all outputs 0.
REQ-036 start held in RUN is ignored; start in DONE gives back-to-back DIV 0x64/0x07 then MUL 0x10*0x10 -> done pulses 9 cycles apart with results (0x0E,0x02) then (0x00,0x01,ov=1).
REQ-037 A build without MCU51_DIV_EN: DIV 0xFB/0x12 -> done after 1 cycle, ov=1, res_a=0xFB, res_b=0x12.
